// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared occupancy encoding and defaults for the FIFO read side
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_e;

  // Next occupancy of the head/skid pair for one edge of land/pop activity.
  function automatic occ_e occ_step(input occ_e occ, input logic land, input logic pop);
    case ({land, pop})
      2'b10:   return (occ == OCC_0) ? OCC_1 : OCC_2;
      2'b01:   return (occ == OCC_2) ? OCC_1 : OCC_0;
      default: return occ;
    endcase
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - two-entry head/skid buffer, head is the presented word
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             land_i,
  input  logic [WIDTH-1:0] land_data_i,
  input  logic             pop_i,
  output occ_e             occ_o,
  output logic [WIDTH-1:0] head_o
);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             head_free;

  always_comb begin
    head_free = (occ_q == OCC_0) || ((occ_q == OCC_1) && pop_i);
    head_d    = head_q;
    skid_d    = skid_q;
    if (pop_i && (occ_q == OCC_2)) begin
      head_d = skid_q;
    end
    // A landing word goes straight to the head whenever the head is vacated this edge.
    if (land_i) begin
      if (head_free) begin
        head_d = land_data_i;
      end else begin
        skid_d = land_data_i;
      end
    end
    occ_d = flush_i ? OCC_0 : occ_step(occ_q, land_i, pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      occ_q  <= OCC_0;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(land_i && (occ_q == OCC_2) && !pop_i));

  assign occ_o  = occ_q;
  assign head_o = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read drain with credit prefetch into a valid/ready stream
// Optional beat counter port and logic enabled by FIFO_RD_STAT_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] rd_data,
  output logic             rd_en,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       buf_level
`ifdef FIFO_RD_STAT_EN
  ,
  output logic [CNT_W-1:0] beat_cnt
`endif
);

  occ_e       occ;
  logic       inflight_q, inflight_d;
  logic       pop_out;
  logic       land;
  logic [2:0] credit;

  assign out_valid = (occ != OCC_0);
  assign buf_level = occ;
  assign pop_out   = out_valid && out_ready && !flush;
  assign land      = inflight_q && !flush;

  // pop_out implies occ >= 1, so the subtraction never wraps.
  assign credit     = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop_out};
  assign rd_en      = rd_rst_n && !fifo_empty && !flush && (credit < 3'd2);
  assign inflight_d = rd_en;

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  fifo_rd_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk_i      (rd_clk),
    .rst_n_i    (rd_rst_n),
    .flush_i    (flush),
    .land_i     (land),
    .land_data_i(rd_data),
    .pop_i      (pop_out),
    .occ_o      (occ),
    .head_o     (out_data)
  );

`ifdef FIFO_RD_STAT_EN
  logic [CNT_W-1:0] beat_q, beat_d;

  always_comb begin
    beat_d = flush ? '0 : beat_q + {{(CNT_W-1){1'b0}}, pop_out};
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign beat_cnt = beat_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed bench for fifo_rd_stream with a queue-based FIFO model
module tb_fifo_rd_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] rd_data = '0;
  logic             rd_en;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       buf_level;
`ifdef FIFO_RD_STAT_EN
  logic [CNT_W-1:0] beat_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .rd_clk    (clk),
    .rd_rst_n  (rst_n),
    .fifo_empty(fifo_empty),
    .rd_data   (rd_data),
    .rd_en     (rd_en),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .buf_level (buf_level)
`ifdef FIFO_RD_STAT_EN
    ,
    .beat_cnt  (beat_cnt)
`endif
  );

  // FIFO model: pop on rd_en && !fifo_empty, data one edge later
  logic [WIDTH-1:0] fq[$];

  always @(posedge clk) begin
    if (rd_en && !fifo_empty) begin
      rd_data <= fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0);
  end

  typedef struct {
    logic       rst_n;
    logic       ready;
    int         push_n;
    logic [7:0] base;
    logic       e_rd;
    logic       e_v;
    logic [7:0] e_d;
    logic [1:0] e_l;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic rdy, input int pn, input logic [7:0] b,
                     input logic erd, input logic ev, input logic [7:0] ed, input logic [1:0] el);
    vec_t v;
    v.rst_n = r; v.ready = rdy; v.push_n = pn; v.base = b;
    v.e_rd = erd; v.e_v = ev; v.e_d = ed; v.e_l = el;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_words(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) fq.push_back(base + 8'(k));
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  function automatic logic [7:0] final_exp(input int idx);
    return (idx < 3) ? 8'(8'h45 + idx) : 8'(8'h50 + idx - 3);
  endfunction

  int seen;
  int gaps;

  initial begin
    // reset (3 cycles, FIFO non-empty), single word 0x1A, then back-pressure on 0x00..0x07
    add(0, 1, 1, 8'h1A, 0, 0, 8'h00, 0);
    add(0, 1, 0, 8'h00, 0, 0, 8'h00, 0);
    add(0, 1, 0, 8'h00, 0, 0, 8'h00, 0);
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0);
    add(1, 1, 0, 8'h00, 0, 0, 8'h00, 0);
    add(1, 1, 0, 8'h00, 0, 1, 8'h1A, 1);
    add(1, 0, 8, 8'h00, 0, 0, 8'h1A, 0);
    add(1, 0, 0, 8'h00, 1, 0, 8'h1A, 0);
    add(1, 0, 0, 8'h00, 1, 0, 8'h1A, 0);
    add(1, 0, 0, 8'h00, 0, 1, 8'h00, 1);
    for (int k = 0; k < 6; k++) add(1, 0, 0, 8'h00, 0, 1, 8'h00, 2);
    add(1, 1, 0, 8'h00, 1, 1, 8'h00, 2);
    for (int k = 1; k <= 5; k++) add(1, 1, 0, 8'h00, 1, 1, 8'(k), 1);
    add(1, 1, 0, 8'h00, 0, 1, 8'h06, 1);
    add(1, 1, 0, 8'h00, 0, 1, 8'h07, 1);
    add(1, 1, 0, 8'h00, 0, 0, 8'h07, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      next_cycle();
      rst_n     = tbl[i].rst_n;
      out_ready = tbl[i].ready;
      flush     = 1'b0;
      push_words(tbl[i].push_n, tbl[i].base);
      #1;
      check($sformatf("row%0d rd_en", i), 32'(rd_en), 32'(tbl[i].e_rd));
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_v));
      check($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].e_d));
      check($sformatf("row%0d buf_level", i), 32'(buf_level), 32'(tbl[i].e_l));
    end

    // streaming: 8 words, ready held high, no gaps once started
    next_cycle();
    out_ready = 1'b1;
    push_words(8, 8'h00);
    seen = 0;
    gaps = 0;
    for (int c = 0; c < 30; c++) begin
      next_cycle();
      #1;
      if (out_valid) begin
        check($sformatf("stream word%0d", seen), 32'(out_data), 32'(seen));
        seen++;
      end else if (seen > 0 && seen < 8) begin
        gaps++;
      end
    end
    check("stream count", 32'(seen), 32'd8);
    check("stream gaps", 32'(gaps), 32'd0);
`ifdef FIFO_RD_STAT_EN
    check("beat_cnt after 17 beats", 32'(beat_cnt), 32'd1);
`endif

    // flush with both entries full while ready is high in the flush cycle
    next_cycle();
    out_ready = 1'b0;
    push_words(8, 8'h40);
    for (int c = 0; c < 4; c++) next_cycle();
    #1;
    check("prefill level", 32'(buf_level), 32'd2);
    check("prefill rd_en", 32'(rd_en), 32'd0);
    check("prefill data", 32'(out_data), 32'h40);

    next_cycle();
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    check("flush1 rd_en forced", 32'(rd_en), 32'd0);

    next_cycle();
    flush = 1'b0;
    #1;
    check("post flush1 valid", 32'(out_valid), 32'd0);
    check("post flush1 level", 32'(buf_level), 32'd0);
    check("post flush1 rd_en", 32'(rd_en), 32'd1);
`ifdef FIFO_RD_STAT_EN
    check("post flush1 beat_cnt", 32'(beat_cnt), 32'd0);
`endif

    next_cycle();
    #1;
    check("refill valid", 32'(out_valid), 32'd0);

    next_cycle();
    #1;
    check("next after flush valid", 32'(out_valid), 32'd1);
    check("next after flush data", 32'(out_data), 32'h42);

    // flush with a head word and one word in flight
    next_cycle();
    flush = 1'b1;
    #1;
    check("flush2 data", 32'(out_data), 32'h43);
    check("flush2 rd_en forced", 32'(rd_en), 32'd0);

    next_cycle();
    flush = 1'b0;
    #1;
    check("post flush2 valid", 32'(out_valid), 32'd0);
    check("post flush2 level", 32'(buf_level), 32'd0);
    push_words(14, 8'h50);

    seen = 0;
    for (int c = 0; c < 60; c++) begin
      next_cycle();
      #1;
      if (out_valid) begin
        check($sformatf("drain word%0d", seen), 32'(out_data), 32'(final_exp(seen)));
        seen++;
      end
    end
    check("drain count", 32'(seen), 32'd17);
`ifdef FIFO_RD_STAT_EN
    check("beat_cnt wrap", 32'(beat_cnt), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
